// File: rtl/imm_pkg.sv
// Shared immediate-table definitions for the encoder and the decoder.
// Holds widths, the FSM state type and the 16-entry table contents.
package imm_pkg;

   localparam int DATA_W = 8;
   localparam int CODE_W = 5;
   localparam int IDX_W  = 4;
   localparam int TBL_N  = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   // Entry order is index 0 first; must match the decoder exactly.
   localparam logic [DATA_W-1:0] IMM_TABLE [TBL_N] = '{
      8'h80, 8'h0F, 8'hEE, 8'h10,
      8'hEB, 8'h00, 8'h3D, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'hFF
   };

endpackage

// File: rtl/imm_table_rom.sv
// Combinational read port on the shared immediate table.
// Ports: idx (4-bit table index) -> value (8-bit table entry).
module imm_table_rom
   import imm_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] value
);

   assign value = IMM_TABLE[idx];

endmodule

// File: rtl/immediate_encoder.sv
// Encodes an 8-bit constant into the 5-bit immediate field, using the
// direct form (0-15) or a one-entry-per-cycle scan of the immediate table.
// Ports: Clk, Reset_n (async, active-low); in_valid/in_ready/in_value
// request side; out_valid/out_ready/out_code/out_miss result side.
module immediate_encoder
   import imm_pkg::*;
#(
   parameter bit PREFER_DIRECT = 1'b1
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_value,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CODE_W-1:0] out_code,
   output logic              out_miss,
   input  logic              out_ready
);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [DATA_W-1:0]  value;
   logic [DATA_W-1:0]  tbl;
   logic               in_small;
   logic               val_small;

   imm_table_rom u_rom (
      .idx   (idx),
      .value (tbl)
   );

   assign in_ready  = (state == IDLE);
   assign in_small  = (in_value[DATA_W-1:IDX_W] == '0);
   assign val_small = (value[DATA_W-1:IDX_W] == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         value     <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         out_miss  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  value <= in_value;
                  if (PREFER_DIRECT && in_small) begin
                     out_code  <= {1'b0, in_value[IDX_W-1:0]};
                     out_miss  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx   <= '0;
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (tbl == value) begin
                  out_code  <= {1'b1, idx};
                  out_miss  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (idx != '1) begin
                  idx <= idx + 1'b1;
               end else begin
                  // Table exhausted: direct form is the fallback.
                  if (val_small) begin
                     out_code <= {1'b0, value[IDX_W-1:0]};
                     out_miss <= 1'b0;
                  end else begin
                     out_code <= '0;
                     out_miss <= 1'b1;
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed bench for immediate_encoder, both PREFER_DIRECT settings.
// Instance 0 uses PREFER_DIRECT=1, instance 1 uses PREFER_DIRECT=0.
module tb_immediate_encoder;

   logic             clk;
   logic             rst_n;
   logic [1:0]       iv;
   logic [1:0][7:0]  ival;
   logic [1:0]       ir;
   logic [1:0]       ov;
   logic [1:0][4:0]  oc;
   logic [1:0]       om;
   logic [1:0]       ordy;

   int n_cmp = 0;
   int n_bad = 0;

   immediate_encoder #(.PREFER_DIRECT(1'b1)) dut0 (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .in_valid  (iv[0]),
      .in_value  (ival[0]),
      .in_ready  (ir[0]),
      .out_valid (ov[0]),
      .out_code  (oc[0]),
      .out_miss  (om[0]),
      .out_ready (ordy[0])
   );

   immediate_encoder #(.PREFER_DIRECT(1'b0)) dut1 (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .in_valid  (iv[1]),
      .in_value  (ival[1]),
      .in_ready  (ir[1]),
      .out_valid (ov[1]),
      .out_code  (oc[1]),
      .out_miss  (om[1]),
      .out_ready (ordy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Issue one request on instance d, measure cycles to out_valid.
   // Leaves the DUT in DONE, sampled #1 after the out_valid edge.
   task automatic issue(input int d, input logic [7:0] v,
                        output int lat);
      @(negedge clk);
      chk($sformatf("ready_pre%0d_%0h", d, v), 32'(ir[d]), 1);
      iv[d]   = 1'b1;
      ival[d] = v;
      @(posedge clk);
      #1;
      iv[d]   = 1'b0;
      ival[d] = 8'hA5;
      lat = 1;
      while (!ov[d] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic req(input int d, input logic [7:0] v,
                      input int elat, input logic [4:0] ecode,
                      input logic emiss);
      int lat;
      issue(d, v, lat);
      chk($sformatf("lat%0d_%0h", d, v), 32'(lat), 32'(elat));
      chk($sformatf("code%0d_%0h", d, v), 32'(oc[d]), 32'(ecode));
      chk($sformatf("miss%0d_%0h", d, v), 32'(om[d]), 32'(emiss));
      chk($sformatf("busy%0d_%0h", d, v), 32'(ir[d]), 0);
      @(posedge clk);
      #1;
      chk($sformatf("drain%0d_%0h", d, v), 32'(ov[d]), 0);
      chk($sformatf("idle%0d_%0h", d, v), 32'(ir[d]), 1);
   endtask

   initial begin
      int lat;
      int acc;
      int cmpl;
      int bub;
      int stale;
      logic prev_acc;

      rst_n = 1'b0;
      iv    = '0;
      ival  = '0;
      ordy  = 2'b11;
      #12;
      chk("rst_ov", 32'(ov), 0);
      chk("rst_oc0", 32'(oc[0]), 0);
      chk("rst_om", 32'(om), 0);
      chk("rst_ir", 32'(ir), 32'h3);
      @(negedge clk);
      rst_n = 1'b1;

      req(0, 8'h07, 1, 5'h07, 1'b0);
      req(0, 8'h80, 2, 5'h10, 1'b0);
      req(0, 8'hEE, 4, 5'h12, 1'b0);
      req(0, 8'hFF, 17, 5'h1F, 1'b0);
      req(0, 8'h0F, 1, 5'h0F, 1'b0);

      // Miss with out_ready withheld: result must hold still.
      ordy[0] = 1'b0;
      issue(0, 8'h55, lat);
      chk("lat_55", 32'(lat), 17);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold_ov%0d", i), 32'(ov[0]), 1);
         chk($sformatf("hold_m%0d", i), 32'(om[0]), 1);
         chk($sformatf("hold_c%0d", i), 32'(oc[0]), 0);
         chk($sformatf("hold_r%0d", i), 32'(ir[0]), 0);
         @(posedge clk);
         #1;
      end
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_rel_ov", 32'(ov[0]), 0);
      chk("hold_rel_ir", 32'(ir[0]), 1);

      req(1, 8'h0F, 3, 5'h11, 1'b0);
      req(1, 8'h00, 7, 5'h15, 1'b0);
      req(1, 8'h03, 17, 5'h03, 1'b0);
      req(1, 8'h3D, 8, 5'h16, 1'b0);

      // Reset in the middle of a scan (cycle c9 of 0xFF).
      @(negedge clk);
      iv[1]   = 1'b1;
      ival[1] = 8'hFF;
      @(posedge clk);
      #1;
      iv[1] = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(ov[1]), 0);
      chk("mid_rst_oc", 32'(oc[1]), 0);
      chk("mid_rst_ir", 32'(ir[1]), 1);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ov[1]) stale++;
      end
      chk("no_stale", 32'(stale), 0);
      req(1, 8'h3D, 8, 5'h16, 1'b0);

      // Back-to-back with in_valid held high on instance 0.
      @(negedge clk);
      iv[0]   = 1'b1;
      ival[0] = 8'h05;
      acc = 0;
      cmpl = 0;
      bub = 0;
      prev_acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            // first sample reflects the negedge just used to drive
         end
         if (iv[0] && ir[0]) begin
            acc++;
            if (prev_acc) bub++;
            prev_acc = 1'b1;
         end else begin
            prev_acc = 1'b0;
         end
         if (ov[0] && ordy[0]) begin
            cmpl++;
            chk($sformatf("b2b_code%0d", i), 32'(oc[0]), 32'h05);
         end
      end
      iv[0] = 1'b0;
      chk("b2b_acc", 32'(acc), 5);
      chk("b2b_done", 32'(cmpl), 5);
      chk("b2b_bubble", 32'(bub), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
